// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master round-robin arbiter onto one shared memory port
//
// Purpose: grants m0 (instruction fetch) or m1 (load/store) access to a single
// memory port with one transaction outstanding, and returns a one-cycle response
// pulse carrying read data or a timeout error.
//
// Ports:
//   CLK100MHZ, ck_rst          clock, synchronous active-low reset
//   mN_req_valid/ready         master request handshake (ready only in IDLE)
//   mN_req_addr/wdata/wstrb    master request fields, wstrb==0 means read
//   mN_resp_valid/rdata/err    one-cycle response pulse to the owner
//   s_req_valid/ready          shared memory request handshake
//   s_req_addr/wdata/wstrb     latched request fields, stable while in REQ
//   s_resp_valid/rdata         shared memory response (honoured only in WAIT)
//   busy                       transaction in flight (REQ or WAIT)
//   grant_id                   current or last owner
//   err_count                  saturating timeout count
module mem_bus_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int STRB_W  = DATA_W / 8,
   parameter int TIMEOUT = 64
) (
   input  logic              CLK100MHZ,
   input  logic              ck_rst,
   input  logic              m0_req_valid,
   output logic              m0_req_ready,
   input  logic [ADDR_W-1:0] m0_req_addr,
   input  logic [DATA_W-1:0] m0_req_wdata,
   input  logic [STRB_W-1:0] m0_req_wstrb,
   output logic              m0_resp_valid,
   output logic [DATA_W-1:0] m0_resp_rdata,
   output logic              m0_resp_err,
   input  logic              m1_req_valid,
   output logic              m1_req_ready,
   input  logic [ADDR_W-1:0] m1_req_addr,
   input  logic [DATA_W-1:0] m1_req_wdata,
   input  logic [STRB_W-1:0] m1_req_wstrb,
   output logic              m1_resp_valid,
   output logic [DATA_W-1:0] m1_resp_rdata,
   output logic              m1_resp_err,
   output logic              s_req_valid,
   input  logic              s_req_ready,
   output logic [ADDR_W-1:0] s_req_addr,
   output logic [DATA_W-1:0] s_req_wdata,
   output logic [STRB_W-1:0] s_req_wstrb,
   input  logic              s_resp_valid,
   input  logic [DATA_W-1:0] s_resp_rdata,
   output logic              busy,
   output logic              grant_id,
   output logic [7:0]        err_count
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

   state_t            state, state_next;
   logic              last_grant;
   logic [7:0]        cnt;
   logic              resp_valid0, resp_valid1, resp_err;
   logic [DATA_W-1:0] resp_rdata;

   logic winner, accept, complete, timeout_hit;

   always_comb begin
      // Tie goes to the master that did not win last; a lone requester always wins.
      if (m0_req_valid && m1_req_valid) winner = ~last_grant;
      else                              winner = m1_req_valid;
      // Gating with ck_rst keeps ready low during a reset cycle.
      accept      = (state == IDLE) && ck_rst && (m0_req_valid || m1_req_valid);
      complete    = (state == WAIT) && s_resp_valid;
      // A completion arriving on the deadline cycle beats the timeout.
      timeout_hit = (state != IDLE) && (cnt == TIMEOUT_CNT) && !complete;
   end

   always_ff @(posedge CLK100MHZ) begin
      if (!ck_rst) state <= IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept) state_next = REQ;
         REQ: begin
            if (timeout_hit)      state_next = IDLE;
            else if (s_req_ready) state_next = WAIT;
         end
         WAIT: if (complete || timeout_hit) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK100MHZ) begin
      if (!ck_rst) begin
         last_grant  <= 1'b1;
         grant_id    <= 1'b0;
         cnt         <= 8'd0;
         err_count   <= 8'd0;
         resp_valid0 <= 1'b0;
         resp_valid1 <= 1'b0;
         resp_err    <= 1'b0;
         resp_rdata  <= '0;
         s_req_addr  <= '0;
         s_req_wdata <= '0;
         s_req_wstrb <= '0;
      end else begin
         resp_valid0 <= 1'b0;
         resp_valid1 <= 1'b0;
         if (accept) begin
            grant_id    <= winner;
            last_grant  <= winner;
            cnt         <= 8'd0;
            s_req_addr  <= winner ? m1_req_addr  : m0_req_addr;
            s_req_wdata <= winner ? m1_req_wdata : m0_req_wdata;
            s_req_wstrb <= winner ? m1_req_wstrb : m0_req_wstrb;
         end else if (state != IDLE && cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
         end
         if (complete) begin
            resp_valid0 <= ~grant_id;
            resp_valid1 <= grant_id;
            resp_err    <= 1'b0;
            resp_rdata  <= s_resp_rdata;
         end else if (timeout_hit) begin
            resp_valid0 <= ~grant_id;
            resp_valid1 <= grant_id;
            resp_err    <= 1'b1;
            resp_rdata  <= '0;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
         end
      end
   end

   assign m0_req_ready  = accept && !winner;
   assign m1_req_ready  = accept && winner;
   assign m0_resp_valid = resp_valid0;
   assign m1_resp_valid = resp_valid1;
   assign m0_resp_err   = resp_err;
   assign m1_resp_err   = resp_err;
   assign m0_resp_rdata = resp_rdata;
   assign m1_resp_rdata = resp_rdata;
   assign s_req_valid   = (state == REQ);
   assign busy          = (state != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_valid, m1_valid, s_ready, s_rvalid;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;
   logic [3:0]  m0_wstrb, m1_wstrb;

   // dut_a: TIMEOUT=64, dut_b: TIMEOUT=4; both see the same stimulus.
   logic        a_m0_ready, a_m0_rv, a_m0_err, a_m1_ready, a_m1_rv, a_m1_err;
   logic [31:0] a_m0_rdata, a_m1_rdata, a_s_addr, a_s_wdata;
   logic [3:0]  a_s_wstrb;
   logic        a_s_valid, a_busy, a_gid;
   logic [7:0]  a_errc;
   logic        b_m0_ready, b_m0_rv, b_m0_err, b_m1_ready, b_m1_rv, b_m1_err;
   logic [31:0] b_m0_rdata, b_m1_rdata, b_s_addr, b_s_wdata;
   logic [3:0]  b_s_wstrb;
   logic        b_s_valid, b_busy, b_gid;
   logic [7:0]  b_errc;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.TIMEOUT(64)) dut_a (
      .CLK100MHZ(clk), .ck_rst(rst),
      .m0_req_valid(m0_valid), .m0_req_ready(a_m0_ready), .m0_req_addr(m0_addr),
      .m0_req_wdata(m0_wdata), .m0_req_wstrb(m0_wstrb), .m0_resp_valid(a_m0_rv),
      .m0_resp_rdata(a_m0_rdata), .m0_resp_err(a_m0_err),
      .m1_req_valid(m1_valid), .m1_req_ready(a_m1_ready), .m1_req_addr(m1_addr),
      .m1_req_wdata(m1_wdata), .m1_req_wstrb(m1_wstrb), .m1_resp_valid(a_m1_rv),
      .m1_resp_rdata(a_m1_rdata), .m1_resp_err(a_m1_err),
      .s_req_valid(a_s_valid), .s_req_ready(s_ready), .s_req_addr(a_s_addr),
      .s_req_wdata(a_s_wdata), .s_req_wstrb(a_s_wstrb), .s_resp_valid(s_rvalid),
      .s_resp_rdata(s_rdata), .busy(a_busy), .grant_id(a_gid), .err_count(a_errc)
   );

   mem_bus_arbiter #(.TIMEOUT(4)) dut_b (
      .CLK100MHZ(clk), .ck_rst(rst),
      .m0_req_valid(m0_valid), .m0_req_ready(b_m0_ready), .m0_req_addr(m0_addr),
      .m0_req_wdata(m0_wdata), .m0_req_wstrb(m0_wstrb), .m0_resp_valid(b_m0_rv),
      .m0_resp_rdata(b_m0_rdata), .m0_resp_err(b_m0_err),
      .m1_req_valid(m1_valid), .m1_req_ready(b_m1_ready), .m1_req_addr(m1_addr),
      .m1_req_wdata(m1_wdata), .m1_req_wstrb(m1_wstrb), .m1_resp_valid(b_m1_rv),
      .m1_resp_rdata(b_m1_rdata), .m1_resp_err(b_m1_err),
      .s_req_valid(b_s_valid), .s_req_ready(s_ready), .s_req_addr(b_s_addr),
      .s_req_wdata(b_s_wdata), .s_req_wstrb(b_s_wstrb), .s_resp_valid(s_rvalid),
      .s_resp_rdata(s_rdata), .busy(b_busy), .grant_id(b_gid), .err_count(b_errc)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
      m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
      s_ready = 0; s_rvalid = 0; s_rdata = 0;
   endtask

   task automatic do_reset();
      rst = 0;
      idle_inputs();
      cyc();
      cyc();
      rst = 1;
   endtask

   task automatic test_reset();
      do_reset();
      rst = 0; m0_valid = 1; m1_valid = 1;
      cyc();
      total++; if (a_m0_ready !== 1'b0) begin bad++; $display("FAIL rst_m0_ready got=%0h exp=0", a_m0_ready); end
      total++; if (a_m1_ready !== 1'b0) begin bad++; $display("FAIL rst_m1_ready got=%0h exp=0", a_m1_ready); end
      total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0h exp=0", a_busy); end
      total++; if (a_s_valid !== 1'b0) begin bad++; $display("FAIL rst_s_valid got=%0h exp=0", a_s_valid); end
      total++; if (a_gid !== 1'b0) begin bad++; $display("FAIL rst_grant_id got=%0h exp=0", a_gid); end
      total++; if (a_errc !== 8'd0) begin bad++; $display("FAIL rst_err_count got=%0h exp=0", a_errc); end
      total++; if ({a_m0_rv, a_m1_rv, a_m0_err, a_m1_err} !== 4'b0) begin bad++; $display("FAIL rst_resp got=%0b exp=0000", {a_m0_rv, a_m1_rv, a_m0_err, a_m1_err}); end
      total++; if (a_m0_rdata !== 32'd0) begin bad++; $display("FAIL rst_rdata got=%0h exp=0", a_m0_rdata); end
      m0_valid = 0; m1_valid = 0; rst = 1;
      cyc();
   endtask

   task automatic test_single_read();
      do_reset();
      s_ready = 1;
      m0_valid = 1; m0_addr = 32'h100; m0_wstrb = 4'h0;
      #1;
      total++; if (a_m0_ready !== 1'b1) begin bad++; $display("FAIL rd_m0_ready got=%0h exp=1", a_m0_ready); end
      total++; if (a_m1_ready !== 1'b0) begin bad++; $display("FAIL rd_m1_ready got=%0h exp=0", a_m1_ready); end
      cyc();
      m0_valid = 0;
      total++; if (a_s_valid !== 1'b1) begin bad++; $display("FAIL rd_s_valid got=%0h exp=1", a_s_valid); end
      total++; if (a_s_addr !== 32'h100) begin bad++; $display("FAIL rd_s_addr got=%0h exp=100", a_s_addr); end
      total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL rd_busy got=%0h exp=1", a_busy); end
      cyc();
      s_rvalid = 1; s_rdata = 32'hDEADBEEF;
      total++; if (a_s_valid !== 1'b0) begin bad++; $display("FAIL rd_wait_s_valid got=%0h exp=0", a_s_valid); end
      total++; if (a_m0_rv !== 1'b0) begin bad++; $display("FAIL rd_early_resp got=%0h exp=0", a_m0_rv); end
      cyc();
      s_rvalid = 0;
      total++; if (a_m0_rv !== 1'b1) begin bad++; $display("FAIL rd_resp_valid got=%0h exp=1", a_m0_rv); end
      total++; if (a_m0_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_rdata got=%0h exp=deadbeef", a_m0_rdata); end
      total++; if (a_m0_err !== 1'b0) begin bad++; $display("FAIL rd_err got=%0h exp=0", a_m0_err); end
      total++; if (a_m1_rv !== 1'b0) begin bad++; $display("FAIL rd_m1_silent got=%0h exp=0", a_m1_rv); end
      total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL rd_busy_end got=%0h exp=0", a_busy); end
      cyc();
      total++; if (a_m0_rv !== 1'b0) begin bad++; $display("FAIL rd_pulse_len got=%0h exp=0", a_m0_rv); end
   endtask

   task automatic test_back_to_back_tie();
      logic exp;
      do_reset();
      s_ready = 1; m0_valid = 1; m1_valid = 1;
      m0_addr = 32'h40; m1_addr = 32'h80;
      #1;
      for (int i = 0; i < 3; i++) begin
         exp = i[0];
         total++; if ({a_m1_ready, a_m0_ready} !== (exp ? 2'b10 : 2'b01)) begin bad++; $display("FAIL tie_ready%0d got=%0b exp=%0b", i, {a_m1_ready, a_m0_ready}, (exp ? 2'b10 : 2'b01)); end
         cyc();
         total++; if (a_gid !== exp) begin bad++; $display("FAIL tie_grant%0d got=%0h exp=%0h", i, a_gid, exp); end
         total++; if (a_s_addr !== (exp ? 32'h80 : 32'h40)) begin bad++; $display("FAIL tie_addr%0d got=%0h exp=%0h", i, a_s_addr, (exp ? 32'h80 : 32'h40)); end
         cyc();
         s_rvalid = 1; s_rdata = 32'hA0 + i;
         cyc();
         s_rvalid = 0;
         total++; if ({a_m1_rv, a_m0_rv} !== (exp ? 2'b10 : 2'b01)) begin bad++; $display("FAIL tie_resp%0d got=%0b exp=%0b", i, {a_m1_rv, a_m0_rv}, (exp ? 2'b10 : 2'b01)); end
         total++; if (a_m0_rdata !== 32'hA0 + i) begin bad++; $display("FAIL tie_rdata%0d got=%0h exp=%0h", i, a_m0_rdata, 32'hA0 + i); end
      end
      m0_valid = 0; m1_valid = 0;
      cyc();
   endtask

   task automatic test_backpressure();
      do_reset();
      s_ready = 0;
      m1_valid = 1; m1_addr = 32'h200; m1_wdata = 32'h12345678; m1_wstrb = 4'hF;
      #1;
      total++; if (a_m1_ready !== 1'b1) begin bad++; $display("FAIL bp_ready got=%0h exp=1", a_m1_ready); end
      cyc();
      m1_valid = 0; m1_addr = 32'hFFFF; m1_wdata = 0; m1_wstrb = 0;
      for (int k = 0; k < 5; k++) begin
         total++; if ({a_s_valid, a_s_addr, a_s_wdata, a_s_wstrb} !== {1'b1, 32'h200, 32'h12345678, 4'hF}) begin bad++; $display("FAIL bp_hold%0d got=%0b/%0h/%0h/%0h exp=1/200/12345678/f", k, a_s_valid, a_s_addr, a_s_wdata, a_s_wstrb); end
         if (k == 4) s_ready = 1;
         cyc();
      end
      s_ready = 0; s_rvalid = 1; s_rdata = 32'h55AA;
      cyc();
      s_rvalid = 0;
      total++; if (a_m1_rv !== 1'b1 || a_m1_err !== 1'b0) begin bad++; $display("FAIL bp_resp got=%0b%0b exp=10", a_m1_rv, a_m1_err); end
      total++; if (a_m1_rdata !== 32'h55AA) begin bad++; $display("FAIL bp_rdata got=%0h exp=55aa", a_m1_rdata); end
      total++; if (a_errc !== 8'd0) begin bad++; $display("FAIL bp_err_count got=%0h exp=0", a_errc); end
   endtask

   task automatic test_simultaneous();
      do_reset();
      s_ready = 1; m0_valid = 1; m0_addr = 32'h180;
      cyc();
      m0_valid = 0;
      // REQ at cnt 0, WAIT from cnt 1; the deadline cycle has cnt == 4.
      for (int k = 1; k < 4; k++) begin
         cyc();
         total++; if (b_m0_rv !== 1'b0 || b_busy !== 1'b1) begin bad++; $display("FAIL sim_wait%0d got=%0b%0b exp=01", k, b_m0_rv, b_busy); end
      end
      cyc();
      s_rvalid = 1; s_rdata = 32'h13579BDF;
      cyc();
      s_rvalid = 0;
      total++; if (b_m0_rv !== 1'b1 || b_m0_err !== 1'b0) begin bad++; $display("FAIL sim_resp got=%0b%0b exp=10", b_m0_rv, b_m0_err); end
      total++; if (b_m0_rdata !== 32'h13579BDF) begin bad++; $display("FAIL sim_rdata got=%0h exp=13579bdf", b_m0_rdata); end
      total++; if (b_errc !== 8'd0) begin bad++; $display("FAIL sim_err_count got=%0h exp=0", b_errc); end
   endtask

   // Runs straight after test_simultaneous so the response register holds non-zero data.
   task automatic test_timeout();
      s_ready = 0; m0_valid = 1; m0_addr = 32'h300; s_rdata = 32'hFFFFFFFF;
      #1;
      total++; if (b_m0_ready !== 1'b1) begin bad++; $display("FAIL to_ready got=%0h exp=1", b_m0_ready); end
      cyc();
      m0_valid = 0;
      for (int k = 0; k < 4; k++) begin
         cyc();
         total++; if (b_m0_rv !== 1'b0 || b_s_valid !== 1'b1) begin bad++; $display("FAIL to_pending%0d got=%0b%0b exp=01", k, b_m0_rv, b_s_valid); end
      end
      cyc();
      total++; if (b_m0_rv !== 1'b1 || b_m0_err !== 1'b1) begin bad++; $display("FAIL to_resp got=%0b%0b exp=11", b_m0_rv, b_m0_err); end
      total++; if (b_m0_rdata !== 32'd0) begin bad++; $display("FAIL to_rdata got=%0h exp=0", b_m0_rdata); end
      total++; if (b_errc !== 8'd1) begin bad++; $display("FAIL to_err_count got=%0h exp=1", b_errc); end
      total++; if (b_s_valid !== 1'b0 || b_busy !== 1'b0) begin bad++; $display("FAIL to_idle got=%0b%0b exp=00", b_s_valid, b_busy); end
      cyc();
      s_rvalid = 1; s_rdata = 32'hBAD;
      cyc();
      s_rvalid = 0;
      total++; if ({b_m0_rv, b_m1_rv} !== 2'b00) begin bad++; $display("FAIL to_late_resp got=%0b exp=00", {b_m0_rv, b_m1_rv}); end
      total++; if (b_errc !== 8'd1 || b_busy !== 1'b0) begin bad++; $display("FAIL to_late_state got=%0h/%0b exp=1/0", b_errc, b_busy); end
   endtask

   task automatic test_midop_reset();
      do_reset();
      s_ready = 1; m0_valid = 1; m0_addr = 32'h500;
      cyc();
      m0_valid = 0;
      cyc();
      total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL mr_in_wait got=%0h exp=1", a_busy); end
      rst = 0;
      cyc();
      rst = 1;
      total++; if (a_busy !== 1'b0 || a_m0_rv !== 1'b0) begin bad++; $display("FAIL mr_abort got=%0b%0b exp=00", a_busy, a_m0_rv); end
      s_rvalid = 1; s_rdata = 32'h77;
      cyc();
      s_rvalid = 0;
      total++; if ({a_m0_rv, a_m1_rv, a_busy} !== 3'b000) begin bad++; $display("FAIL mr_stale got=%0b exp=000", {a_m0_rv, a_m1_rv, a_busy}); end
      m0_valid = 1; m1_valid = 1;
      #1;
      total++; if ({a_m1_ready, a_m0_ready} !== 2'b01) begin bad++; $display("FAIL mr_tie got=%0b exp=01", {a_m1_ready, a_m0_ready}); end
      m0_valid = 0; m1_valid = 0;
      cyc();
   endtask

   initial begin
      rst = 0;
      idle_inputs();
      test_reset();
      test_single_read();
      test_back_to_back_tie();
      test_backpressure();
      test_simultaneous();
      test_timeout();
      test_midop_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
